// File: rtl/flash_loader_pkg.sv
// flash_loader_pkg: shared types and sizing helpers for the flash boot loader.
//   state_t        : loader FSM states
//   word_count_t   : 16-bit word count carried in the stream header
//   calc_bpw       : bytes per flash word for a given data width
//   calc_max_words : words that fit between BASE_ADDR and the top of flash
package flash_loader_pkg;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERROR
  } state_t;

  typedef logic [15:0] word_count_t;

  localparam int DEFAULT_WIDTH = 32;

  function automatic int calc_bpw(input int width);
    return width / 8;
  endfunction

  function automatic int calc_max_words(input int width, input int addr_w, input int base_addr);
    return ((1 << addr_w) / calc_bpw(width)) - (base_addr / calc_bpw(width));
  endfunction

endpackage

// File: rtl/flash_loader_byte_packer.sv
// flash_loader_byte_packer: assembles little-endian words from a byte stream.
//   clk, rst   : clock, synchronous active-high reset (clears the lane index)
//   accept     : a byte is consumed this cycle
//   in_data    : the byte being consumed
//   word_next  : word as it will be once this cycle's byte lands (combinational)
//   word_full  : this cycle's byte completes the word
module flash_loader_byte_packer
  import flash_loader_pkg::*;
#(
  parameter int BPW = calc_bpw(DEFAULT_WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic [7:0]       in_data,
  output logic [BPW*8-1:0] word_next,
  output logic             word_full
);

  localparam int               IDX_W    = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [IDX_W-1:0] idx_reg;

  assign word_full = accept && (idx_reg == LAST_IDX);

  // Index reset on rst is what discards a partially received word.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg <= '0;
    end else if (accept) begin
      idx_reg <= word_full ? '0 : idx_reg + IDX_ONE;
    end
  end

  // Lane storage needs no reset: every lane is rewritten before a word is used.
  generate
    for (genvar gi = 0; gi < BPW; gi++) begin : g_lane
      localparam logic [IDX_W-1:0] LANE_IDX = IDX_W'(gi);
      logic [7:0] lane_reg;
      logic       lane_hit;

      assign lane_hit = accept && (idx_reg == LANE_IDX);

      always_ff @(posedge clk) begin
        if (lane_hit) begin
          lane_reg <= in_data;
        end
      end

      // Bypass lets the final byte merge into the word in the same cycle.
      assign word_next[gi*8 +: 8] = lane_hit ? in_data : lane_reg;
    end
  endgenerate

endmodule

// File: rtl/flash_loader.sv
// flash_loader: boot-time loader that writes a byte-stream image into the
// instruction flash and holds the CPU in reset until the load completes.
//   clk, rst     : clock, synchronous active-high reset
//   in_valid     : input byte valid
//   in_data      : input byte
//   in_ready     : loader accepts in_data this cycle
//   flash_en     : one-cycle flash write strobe
//   flash_addr   : flash byte address (holds between writes)
//   flash_data   : flash write word (holds between writes)
//   cpu_rst      : CPU reset hold, released one cycle after DONE is entered
//   done / error : sticky load-complete / load-aborted flags
// Stream: 2-byte little-endian word count N, then N words LSB first.
// Optional macro FLASH_LOADER_CHECKSUM_EN: a trailing XOR checksum byte
// over all data bytes must match or the load ends in ERROR.
module flash_loader
  import flash_loader_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ADDR_W    = 11,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              flash_en,
  output logic [ADDR_W-1:0] flash_addr,
  output logic [WIDTH-1:0]  flash_data,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);

  localparam int                BPW         = calc_bpw(WIDTH);
  localparam int                MAX_WORDS   = calc_max_words(WIDTH, ADDR_W, BASE_ADDR);
  localparam logic [16:0]       MAX_WORDS_W = 17'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] BPW_A       = ADDR_W'(BPW);
  localparam logic [ADDR_W-1:0] BASE_A      = ADDR_W'(BASE_ADDR);

`ifdef FLASH_LOADER_CHECKSUM_EN
  localparam state_t AFTER_LAST = CSUM;
`else
  localparam state_t AFTER_LAST = DONE;
`endif

  state_t            state_reg, state_next;
  logic              armed_reg;
  logic              release_reg;
  logic [7:0]        len_lo_reg;
  word_count_t       words_left_reg;
  word_count_t       len_in;
  logic [ADDR_W-1:0] addr_cnt_reg;
  logic [ADDR_W-1:0] flash_addr_reg;
  logic [WIDTH-1:0]  flash_data_reg;
  logic [WIDTH-1:0]  word_next;
  logic              accept;
  logic              pack_accept;
  logic              word_full;

  assign accept      = in_valid && in_ready;
  assign pack_accept = accept && (state_reg == DATA);
  assign len_in      = {in_data, len_lo_reg};

  flash_loader_byte_packer #(
    .BPW(BPW)
  ) u_packer (
    .clk      (clk),
    .rst      (rst),
    .accept   (pack_accept),
    .in_data  (in_data),
    .word_next(word_next),
    .word_full(word_full)
  );

`ifdef FLASH_LOADER_CHECKSUM_EN
  logic [7:0] csum_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      csum_reg <= '0;
    end else if (pack_accept) begin
      csum_reg <= csum_reg ^ in_data;
    end
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= LEN_LO;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      LEN_LO: if (accept) state_next = LEN_HI;
      LEN_HI: begin
        if (accept) begin
          if (len_in == '0) begin
            state_next = AFTER_LAST;
          end else if ({1'b0, len_in} > MAX_WORDS_W) begin
            state_next = ERROR;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA:  if (word_full) state_next = WRITE;
      WRITE: state_next = (words_left_reg == 16'd1) ? AFTER_LAST : DATA;
`ifdef FLASH_LOADER_CHECKSUM_EN
      CSUM:  if (accept) state_next = (in_data == csum_reg) ? DONE : ERROR;
`endif
      default: state_next = state_reg;
    endcase
  end

  // Datapath: length capture, address/word counters, held write outputs.
  // flash_addr/flash_data are loaded as the word completes so they are
  // valid during WRITE and hold afterwards, while addr_cnt_reg runs ahead.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed_reg      <= 1'b0;
      release_reg    <= 1'b0;
      len_lo_reg     <= '0;
      words_left_reg <= '0;
      addr_cnt_reg   <= BASE_A;
      flash_addr_reg <= BASE_A;
      flash_data_reg <= '0;
    end else begin
      armed_reg   <= 1'b1;
      release_reg <= (state_reg == DONE);
      if (accept && (state_reg == LEN_LO)) begin
        len_lo_reg <= in_data;
      end
      if (accept && (state_reg == LEN_HI)) begin
        words_left_reg <= len_in;
      end
      if (word_full) begin
        flash_data_reg <= word_next;
        flash_addr_reg <= addr_cnt_reg;
      end
      if (state_reg == WRITE) begin
        addr_cnt_reg   <= addr_cnt_reg + BPW_A;
        words_left_reg <= words_left_reg - 16'd1;
      end
    end
  end

  // Outputs; armed_reg keeps in_ready low through the reset cycle.
  always_comb begin
    in_ready   = armed_reg && (state_reg inside {LEN_LO, LEN_HI, DATA, CSUM});
    flash_en   = (state_reg == WRITE);
    flash_addr = flash_addr_reg;
    flash_data = flash_data_reg;
    done       = (state_reg == DONE);
    error      = (state_reg == ERROR);
    cpu_rst    = ~release_reg;
  end

endmodule

// File: tb/tb_flash_loader.sv
// tb_flash_loader: scoreboard bench for flash_loader. Expected writes are
// queued as image words are driven and popped when flash_en is observed.
module tb_flash_loader;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 11;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              flash_en;
  logic [ADDR_W-1:0] flash_addr;
  logic [WIDTH-1:0]  flash_data;
  logic              cpu_rst;
  logic              done;
  logic              error;

  always #5 clk = ~clk;

  flash_loader #(
    .WIDTH    (WIDTH),
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .flash_en  (flash_en),
    .flash_addr(flash_addr),
    .flash_data(flash_data),
    .cpu_rst   (cpu_rst),
    .done      (done),
    .error     (error)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
  } wr_t;

  wr_t         exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_wr  = 0;
  logic        prev_en = 1'b0;
  logic [31:0] img [16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor: one line per flash write, compared against the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b0 && flash_en === 1'b1) begin
      wr_t e;
      n_wr++;
      $display("write addr=%0h data=%08h", flash_addr, flash_data);
      check("en_width", 64'(prev_en), 64'(0));
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(flash_addr), 64'(e.addr));
        check("wr_data", 64'(flash_data), 64'(e.data));
      end
    end
    prev_en <= flash_en;
  end

  // All driving tasks start and end just after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    bit ok;
    ok  = 1'b0;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    in_valid = 1'b0;
    repeat (gap) begin
      in_data = 8'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!ok) check("accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic send_image(input int n, input int gap, input bit bad_csum);
    logic [7:0]  x;
    logic [15:0] nn;
    x  = 8'h00;
    nn = 16'(n);
    send_byte(nn[7:0], gap);
    send_byte(nn[15:8], gap);
    for (int w = 0; w < n; w++) begin
      exp_q.push_back('{addr: ADDR_W'(w * 4), data: img[w]});
      for (int b = 0; b < 4; b++) begin
        logic [7:0] by;
        by = img[w][b*8 +: 8];
        x  = x ^ by;
        send_byte(by, gap);
      end
    end
`ifdef FLASH_LOADER_CHECKSUM_EN
    send_byte(bad_csum ? (x ^ 8'h01) : x, gap);
`else
    if (bad_csum) x = 8'h00;
`endif
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Waits on negedges until done or error; leaves time at that negedge.
  task automatic wait_end(input string tag, input int budget);
    bit hit;
    hit = 1'b0;
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      if (done || error) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) check({tag, "_timeout"}, 64'(0), 64'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_flash_en", 64'(flash_en), 64'(0));
    check("rst_addr", 64'(flash_addr), 64'(0));
    check("rst_data", 64'(flash_data), 64'(0));
    check("rst_cpu_rst", 64'(cpu_rst), 64'(1));
    check("rst_done", 64'(done), 64'(0));
    check("rst_error", 64'(error), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Two-word image: 12345 at 0, 678910 at 4
    img[0] = 32'd12345;
    img[1] = 32'd678910;
    wr0 = n_wr;
    send_image(2, 0, 1'b0);
    wait_end("two_word", 10);
    check("two_word_done", 64'(done), 64'(1));
    check("two_word_cpu_rst_first", 64'(cpu_rst), 64'(1));
    @(negedge clk);
    check("two_word_cpu_rst_released", 64'(cpu_rst), 64'(0));
    check("two_word_in_ready", 64'(in_ready), 64'(0));
    check("two_word_writes", 64'(n_wr - wr0), 64'(2));
    check("two_word_hold_addr", 64'(flash_addr), 64'(4));
    check("two_word_hold_data", 64'(flash_data), 64'(678910));

    // Zero-length image
    do_reset();
    wr0 = n_wr;
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef FLASH_LOADER_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    wait_end("zero_len", 2);
    check("zero_len_done", 64'(done), 64'(1));
    @(negedge clk);
    check("zero_len_cpu_rst", 64'(cpu_rst), 64'(0));
    check("zero_len_writes", 64'(n_wr - wr0), 64'(0));

    // Oversize length 513 > 512
    do_reset();
    wr0 = n_wr;
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    wait_end("oversize", 3);
    check("oversize_error", 64'(error), 64'(1));
    check("oversize_done", 64'(done), 64'(0));
    check("oversize_in_ready", 64'(in_ready), 64'(0));
    repeat (3) @(negedge clk);
    check("oversize_cpu_rst", 64'(cpu_rst), 64'(1));
    check("oversize_writes", 64'(n_wr - wr0), 64'(0));

    // Eight words, gap-free then with random in_valid gaps
    for (int i = 0; i < 8; i++) img[i] = $urandom;
    for (int run = 0; run < 2; run++) begin
      do_reset();
      wr0 = n_wr;
      send_image(8, (run == 0) ? 0 : 5, 1'b0);
      wait_end("eight_word", 10);
      check("eight_word_done", 64'(done), 64'(1));
      check("eight_word_writes", 64'(n_wr - wr0), 64'(8));
      check("eight_word_hold_addr", 64'(flash_addr), 64'(28));
    end

    // Reset in the middle of word 3, then reload a single word
    do_reset();
    wr0 = n_wr;
    send_byte(8'h08, 0);
    send_byte(8'h00, 0);
    for (int w = 0; w < 3; w++) begin
      exp_q.push_back('{addr: ADDR_W'(w * 4), data: img[w]});
      for (int b = 0; b < 4; b++) send_byte(img[w][b*8 +: 8], 0);
    end
    send_byte(img[3][7:0], 0);
    send_byte(img[3][15:8], 0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_writes", 64'(n_wr - wr0), 64'(3));
    do_reset();
    @(negedge clk);
    check("abort_cpu_rst", 64'(cpu_rst), 64'(1));
    check("abort_in_ready", 64'(in_ready), 64'(0));
    check("abort_addr", 64'(flash_addr), 64'(0));
    check("abort_data", 64'(flash_data), 64'(0));
    @(posedge clk);
    #1;
    img[0] = 32'hDEADBEEF;
    wr0 = n_wr;
    send_image(1, 0, 1'b0);
    wait_end("reload", 10);
    check("reload_done", 64'(done), 64'(1));
    check("reload_writes", 64'(n_wr - wr0), 64'(1));

`ifdef FLASH_LOADER_CHECKSUM_EN
    // Checksum: 01^02^03^04 = 04 accepted, 05 rejected
    img[0] = 32'h04030201;
    do_reset();
    send_image(1, 0, 1'b0);
    wait_end("csum_good", 10);
    check("csum_good_done", 64'(done), 64'(1));
    check("csum_good_error", 64'(error), 64'(0));
    do_reset();
    send_image(1, 0, 1'b1);
    wait_end("csum_bad", 10);
    check("csum_bad_error", 64'(error), 64'(1));
    check("csum_bad_done", 64'(done), 64'(0));
    repeat (2) @(negedge clk);
    check("csum_bad_cpu_rst", 64'(cpu_rst), 64'(1));
`endif

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
